sm_addsub_pipe: RTL and testbench

//  Parametrised, pipelined sign-magnitude add/subtract/compare unit; successor to the 4-bit combinational integrated adder.

---
 rtl/sm_addsub_pipe_pkg.sv | 21 ++
 rtl/sm_addsub_pipe_core.sv | 77 +++++++
 rtl/sm_addsub_pipe.sv | 165 ++++++++++++++++
 tb/tb_sm_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_addsub_pipe_pkg.sv
// Shared types for the sign-magnitude add/sub pipeline.
package sm_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

  // ACC and CLR both touch the accumulator and must not overlap in flight
  function automatic logic is_acc_op(input op_e op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// Width-parametrised sign-magnitude value; a package cannot carry W itself
`ifndef SM_T
`define SM_T(WIDTH) struct packed { logic s; logic [WIDTH-1:0] m; }
`endif

// File: rtl/sm_addsub_pipe_core.sv
// Combinational sign-magnitude math: S1 classification and S2 result.
module sm_core
  import sm_pkg::*;
#(
  parameter int          W        = 4,
  parameter logic [W-1:0] ACC_INIT = '0
) (
  // S1 side: operands as accepted (A already replaced by acc for OP_ACC)
  input  op_e          i_op,
  input  logic         i_as,
  input  logic [W-1:0] i_am,
  input  logic         i_bs,
  input  logic [W-1:0] i_bm,
  output logic         o_eff_sub,
  output logic         o_a_ge_b,
  output logic         o_eq,
  output logic         o_lt,
  // S2 side: registered S1 state
  input  op_e          i_s2_op,
  input  logic         i_s2_as,
  input  logic [W-1:0] i_s2_am,
  input  logic [W-1:0] i_s2_bm,
  input  logic         i_s2_eff_sub,
  input  logic         i_s2_a_ge_b,
  input  logic         i_s2_eq,
  input  logic         i_s2_lt,
  output logic         o_ys,
  output logic [W-1:0] o_ym,
  output logic         o_of,
  output logic         o_eq_q,
  output logic         o_lt_q
);

  logic         w_bs_eff;
  logic         w_neg_a;
  logic         w_neg_b;
  logic [W:0]   w_sum;
  logic [W-1:0] w_diff;

  // Subtract flips B's sign; compare always uses the original B
  assign w_bs_eff  = i_bs ^ (i_op == OP_SUB);
  assign o_eff_sub = i_as ^ w_bs_eff;
  assign o_a_ge_b  = (i_am >= i_bm);

  // -0 is treated as +0 for ordering
  assign w_neg_a = i_as & (|i_am);
  assign w_neg_b = i_bs & (|i_bm);
  assign o_eq    = (i_am == i_bm) && ((i_as == i_bs) || (i_am == '0));
  assign o_lt    = (w_neg_a != w_neg_b) ? w_neg_a :
                   (w_neg_a ? (i_am > i_bm) : (i_am < i_bm));

  assign w_sum  = {1'b0, i_s2_am} + {1'b0, i_s2_bm};
  assign w_diff = i_s2_a_ge_b ? (i_s2_am - i_s2_bm) : (i_s2_bm - i_s2_am);

  // Result select: CLR constant, same-sign add with carry-out, or magnitude difference
  always_comb begin
    o_ys   = 1'b0;
    o_ym   = '0;
    o_of   = 1'b0;
    o_eq_q = i_s2_eq;
    o_lt_q = i_s2_lt;
    if (i_s2_op == OP_CLR) begin
      o_ym   = ACC_INIT;
      o_eq_q = 1'b0;
      o_lt_q = 1'b0;
    end else if (!i_s2_eff_sub) begin
      o_ym = w_sum[W-1:0];
      o_of = w_sum[W];
      o_ys = i_s2_as;
    end else begin
      o_ym = w_diff;
      o_ys = i_s2_a_ge_b ? i_s2_as : ~i_s2_as;
    end
    if (o_ym == '0) o_ys = 1'b0;
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude add/sub/compare unit with valid/ready and accumulator.
module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int           W        = 4,
  parameter logic [W-1:0] ACC_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_e          in_op,
  input  logic         in_as,
  input  logic [W-1:0] in_am,
  input  logic         in_bs,
  input  logic [W-1:0] in_bm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ys,
  output logic [W-1:0] out_ym,
  output logic         out_of,
  output logic         out_eq,
  output logic         out_lt
);

  typedef `SM_T(W) sm_t;

  sm_t          r_acc;

  logic         r_s1_vld;
  op_e          r_s1_op;
  logic         r_s1_as;
  logic [W-1:0] r_s1_am;
  logic [W-1:0] r_s1_bm;
  logic         r_s1_eff_sub;
  logic         r_s1_a_ge_b;
  logic         r_s1_eq;
  logic         r_s1_lt;

  logic         r_s2_vld;
  op_e          r_s2_op;
  sm_t          r_y;
  logic         r_of;
  logic         r_eq;
  logic         r_lt;

  sm_t          w_a;
  logic         w_s2_stall;
  logic         w_s1_hold;
  logic         w_hazard;
  logic         w_accept;
  logic         w_s2_load;
  logic         w_eff_sub;
  logic         w_a_ge_b;
  logic         w_eq;
  logic         w_lt;
  logic         w_ys;
  logic [W-1:0] w_ym;
  logic         w_of;
  logic         w_eq_q;
  logic         w_lt_q;

  // Accumulate reads acc at accept; the hazard guarantees acc is settled then
  assign w_a        = (in_op == OP_ACC) ? r_acc : sm_t'({in_as, in_am});
  assign w_s2_stall = r_s2_vld && !out_ready;
  assign w_s1_hold  = r_s1_vld && w_s2_stall;
  assign w_hazard   = is_acc_op(in_op) &&
                      ((r_s1_vld && is_acc_op(r_s1_op)) || (r_s2_vld && is_acc_op(r_s2_op)));
  assign in_ready   = rst_n && !w_s1_hold && !w_hazard;
  assign w_accept   = in_valid && in_ready;
  assign w_s2_load  = r_s1_vld && !w_s2_stall;

  sm_core #(.W(W), .ACC_INIT(ACC_INIT)) u_core (
    .i_op         (in_op),
    .i_as         (w_a.s),
    .i_am         (w_a.m),
    .i_bs         (in_bs),
    .i_bm         (in_bm),
    .o_eff_sub    (w_eff_sub),
    .o_a_ge_b     (w_a_ge_b),
    .o_eq         (w_eq),
    .o_lt         (w_lt),
    .i_s2_op      (r_s1_op),
    .i_s2_as      (r_s1_as),
    .i_s2_am      (r_s1_am),
    .i_s2_bm      (r_s1_bm),
    .i_s2_eff_sub (r_s1_eff_sub),
    .i_s2_a_ge_b  (r_s1_a_ge_b),
    .i_s2_eq      (r_s1_eq),
    .i_s2_lt      (r_s1_lt),
    .o_ys         (w_ys),
    .o_ym         (w_ym),
    .o_of         (w_of),
    .o_eq_q       (w_eq_q),
    .o_lt_q       (w_lt_q)
  );

  // S1 occupancy: fills on accept, holds while S2 is stalled
  always_ff @(posedge clk) begin
    if (!rst_n)          r_s1_vld <= 1'b0;
    else if (!w_s1_hold) r_s1_vld <= w_accept;
  end

  // S1 payload: operand classification captured on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_op      <= OP_ADD;
      r_s1_as      <= 1'b0;
      r_s1_am      <= '0;
      r_s1_bm      <= '0;
      r_s1_eff_sub <= 1'b0;
      r_s1_a_ge_b  <= 1'b0;
      r_s1_eq      <= 1'b0;
      r_s1_lt      <= 1'b0;
    end else if (w_accept) begin
      r_s1_op      <= in_op;
      r_s1_as      <= w_a.s;
      r_s1_am      <= w_a.m;
      r_s1_bm      <= in_bm;
      r_s1_eff_sub <= w_eff_sub;
      r_s1_a_ge_b  <= w_a_ge_b;
      r_s1_eq      <= w_eq;
      r_s1_lt      <= w_lt;
    end
  end

  // S2 output register: frozen while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_op  <= OP_ADD;
      r_y      <= '0;
      r_of     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      if (!w_s2_stall) r_s2_vld <= r_s1_vld;
      if (w_s2_load) begin
        r_s2_op <= r_s1_op;
        r_y     <= sm_t'({w_ys, w_ym});
        r_of    <= w_of;
        r_eq    <= w_eq_q;
        r_lt    <= w_lt_q;
      end
    end
  end

  // Accumulator: written as the beat enters S2; an overflowing ACC leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= sm_t'({1'b0, ACC_INIT});
    end else if (w_s2_load) begin
      if (r_s1_op == OP_CLR)                r_acc <= sm_t'({1'b0, ACC_INIT});
      else if (r_s1_op == OP_ACC && !w_of) r_acc <= sm_t'({w_ys, w_ym});
    end
  end

  assign out_valid = r_s2_vld;
  assign out_ys    = r_y.s;
  assign out_ym    = r_y.m;
  assign out_of    = r_of;
  assign out_eq    = r_eq;
  assign out_lt    = r_lt;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Scoreboard bench for sm_addsub_pipe (W=4).
module tb_sm_addsub_pipe;
  import sm_pkg::*;

  localparam int           W        = 4;
  localparam logic [W-1:0] ACC_INIT = 4'd0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  op_e          in_op = OP_ADD;
  logic         in_as = 1'b0;
  logic [W-1:0] in_am = '0;
  logic         in_bs = 1'b0;
  logic [W-1:0] in_bm = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_ys;
  logic [W-1:0] out_ym;
  logic         out_of;
  logic         out_eq;
  logic         out_lt;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;
  int macc  = 0;
  logic [W+3:0] sb[$];

  sm_addsub_pipe #(.W(W), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_as(in_as), .in_am(in_am), .in_bs(in_bs), .in_bm(in_bm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ys(out_ys), .out_ym(out_ym), .out_of(out_of), .out_eq(out_eq), .out_lt(out_lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic
  function automatic logic [W+3:0] model(input op_e op, input logic as, input logic [W-1:0] am,
                                         input logic bs, input logic [W-1:0] bm,
                                         input int acc_i, output int acc_o);
    int va, vb, vbe, t, mag;
    logic [W-1:0] ym;
    logic ys, of, eq, lt;
    acc_o = acc_i;
    if (op == OP_CLR) begin
      acc_o = int'(ACC_INIT);
      return {1'b0, ACC_INIT, 3'b000};
    end
    va  = (op == OP_ACC) ? acc_i : (as ? -int'(am) : int'(am));
    vb  = bs ? -int'(bm) : int'(bm);
    vbe = (op == OP_SUB) ? -vb : vb;
    t   = va + vbe;
    mag = (t < 0) ? -t : t;
    of  = (mag > (1 << W) - 1);
    ym  = W'(mag % (1 << W));
    ys  = (t < 0) && (ym != '0);
    eq  = (va == vb);
    lt  = (va < vb);
    if (op == OP_ACC && !of) acc_o = t;
    return {ys, ym, of, eq, lt};
  endfunction

  function automatic logic [W+3:0] outs();
    return {out_ys, out_ym, out_of, out_eq, out_lt};
  endfunction

  // Monitor: push on accept, pop and compare on consume
  initial begin
    int nacc;
    logic [W+3:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        macc = int'(ACC_INIT);
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) chk("spurious_out", 1, 0);
          else begin
            e = sb.pop_front();
            chk("res", outs(), e);
          end
        end
        if (in_valid && in_ready) begin
          n_acc++;
          sb.push_back(model(in_op, in_as, in_am, in_bs, in_bm, macc, nacc));
          macc = nacc;
        end
      end
    end
  end

  task automatic send(input op_e op, input logic as, input logic [W-1:0] am,
                      input logic bs, input logic [W-1:0] bm);
    int n = 0;
    in_op = op; in_as = as; in_am = am; in_bs = bs; in_bm = bm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [W+3:0] exp);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
    else            chk(tag, outs(), exp);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_out;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_outs", outs(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // 1: -3 + +2 with exact 2-cycle latency
    send(OP_ADD, 1'b1, 4'd3, 1'b0, 4'd2);
    @(negedge clk);
    chk("lat_s1", out_valid, 0);
    @(negedge clk);
    chk("lat_s2", out_valid, 1);
    chk("t1_res", outs(), {1'b1, 4'd1, 1'b0, 1'b0, 1'b1});
    drain();

    // 2,3: overflow and zero cases, back to back
    send(OP_ADD, 1'b0, 4'd14, 1'b0, 4'd3);
    send(OP_SUB, 1'b0, 4'd15, 1'b1, 4'd15);
    send(OP_SUB, 1'b1, 4'd15, 1'b0, 4'd15);
    send(OP_SUB, 1'b0, 4'd0,  1'b1, 4'd0);
    send(OP_ADD, 1'b1, 4'd4,  1'b0, 4'd4);
    drain();

    // 4: consumer stall with three beats offered
    base_acc = n_acc;
    base_out = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(OP_ADD, 1'b0, 4'd1, 1'b0, 4'd2);
        send(OP_SUB, 1'b1, 4'd7, 1'b1, 4'd2);
        send(OP_ADD, 1'b1, 4'd9, 1'b0, 4'd3);
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          @(negedge clk);
          if (i >= 3) begin
            chk("stall_vld", out_valid, 1);
            if (sb.size() > 0) chk("stall_hold", outs(), sb[0]);
          end
        end
        chk("stall_rdy", in_ready, 0);
        chk("stall_acc", n_acc - base_acc, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cnt", n_out - base_out, 3);

    // Random mix with random backpressure
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(op_e'(2'($urandom_range(0, 3))), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      begin
        repeat (60) begin
          @(posedge clk); #2;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // 5: accumulate sequence
    send(OP_CLR, 1'b0, 4'd0, 1'b0, 4'd0);
    send(OP_ACC, 1'b0, 4'd0, 1'b0, 4'd5);
    @(negedge clk); chk("acc_haz1", in_ready, 0);
    send(OP_ACC, 1'b0, 4'd0, 1'b1, 4'd7);
    @(negedge clk); chk("acc_haz2", in_ready, 0);
    send(OP_ACC, 1'b0, 4'd0, 1'b0, 4'd13);
    @(negedge clk); chk("acc_haz3", in_ready, 0);
    send(OP_ACC, 1'b0, 4'd0, 1'b0, 4'd7);
    drain();
    send(OP_ACC, 1'b0, 4'd0, 1'b0, 4'd0);
    wait_res("acc_hold", {1'b0, 4'd11, 1'b0, 1'b0, 1'b0});
    drain();

    // 6: reset with two beats in flight
    send(OP_ADD, 1'b0, 4'd3, 1'b0, 4'd4);
    send(OP_SUB, 1'b0, 4'd9, 1'b0, 4'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flush", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(OP_ACC, 1'b0, 4'd0, 1'b0, 4'd0);
    wait_res("acc_rst", {1'b0, ACC_INIT, 1'b0, 1'b1, 1'b0});
    drain();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
